// File: rtl/serial_word_pipe_pkg.sv
// serial_word_pipe_pkg
//   Shared types and helpers for the serial word pipeline:
//   - mode_e     : decode mode latched with each word (pass-through / Gray)
//   - gray2bin   : Gray-to-binary conversion for any width up to 64 bits
//   - log2_ceil  : ceiling log2, used to size FIFO pointers
package serial_word_pipe_pkg;

  typedef enum logic {
    MODE_PASS = 1'b0,
    MODE_GRAY = 1'b1
  } mode_e;

  localparam int unsigned FIFO_DEPTH_DEFAULT = 32'd4;

  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = 32'(i + 1);
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  localparam int unsigned FIFO_PTR_W_DEFAULT = log2_ceil(FIFO_DEPTH_DEFAULT);

  // Bits above 'width' are masked off first, so the 64-bit ripple from the
  // top yields exactly b[w-1]=g[w-1], b[i]=b[i+1]^g[i] for the live bits.
  function automatic logic [63:0] gray2bin(input logic [63:0] gray, input int unsigned width);
    logic [63:0] masked;
    logic [63:0] bin;
    if (width >= 32'd64) begin
      masked = gray;
    end else begin
      masked = gray & ((64'd1 << width) - 64'd1);
    end
    bin     = 64'd0;
    bin[63] = masked[63];
    for (int i = 62; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ masked[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/serial_word_pipe_if.sv
// serial_word_pipe_if
//   Bundles the serial input stream, the per-word controls and the result
//   stream of serial_word_pipe.
//   master : producer/consumer side (drives dataIn, dataInValid, control,
//            coef, dataOutReady; observes results and status)
//   slave  : the pipeline itself
interface serial_word_pipe_if #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                    dataIn;
  logic                    dataInValid;
  logic                    control;
  logic [DATA_WIDTH-1:0]   coef;
  logic [2*DATA_WIDTH-1:0] dataOut;
  logic                    dataOutValid;
  logic                    dataOutReady;
  logic                    overflow;
  logic [CNT_WIDTH-1:0]    wordCount;

  modport master (
    output dataIn, dataInValid, control, coef, dataOutReady,
    input  dataOut, dataOutValid, overflow, wordCount
  );

  modport slave (
    input  dataIn, dataInValid, control, coef, dataOutReady,
    output dataOut, dataOutValid, overflow, wordCount
  );
endinterface

// File: rtl/serial_word_pipe_word_fifo.sv
// word_fifo
//   Synchronous FIFO, DEPTH entries (power of two) of WIDTH bits.
//   Ports: clk, reset (sync, active-high), push/din, pop/dout, full, empty.
//   A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
//   when a pop happens in the same cycle. dout reads 0 while empty.
module word_fifo
  import serial_word_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = int'(log2_ceil(32'(DEPTH)));

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Status flags, accepted operations and head read-out.
  always_comb begin
    full    = (count == (PTR_W+1)'(DEPTH));
    empty   = (count == (PTR_W+1)'(0));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = empty ? WIDTH'(0) : mem[rd_ptr];
  end

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH = 2^PTR_W).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      count  <= (PTR_W+1)'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(0);
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/serial_word_pipe.sv
// serial_word_pipe
//   Shifts a serial bit stream (MSB first) into DATA_WIDTH-bit words, then
//   runs each word through sync -> decode -> multiply stages and buffers the
//   2*DATA_WIDTH-bit products in an output FIFO with valid/ready handshake.
//   Ports: fastClk (sole clock), reset (sync, active-high),
//          bus (slave side of serial_word_pipe_if: serial input, control,
//          coef, dataOut/dataOutValid/dataOutReady, overflow, wordCount).
module serial_word_pipe
  import serial_word_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = int'(FIFO_DEPTH_DEFAULT),
  parameter int CNT_WIDTH  = 16
) (
  input logic               fastClk,
  input logic               reset,
  serial_word_pipe_if.slave bus
);
  localparam int BCW = int'(log2_ceil(32'(DATA_WIDTH)));
  localparam int PW  = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BCW-1:0]        bit_cnt;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  sync_valid;
  logic [DATA_WIDTH-1:0] sync_data;
  mode_e                 sync_mode;
  logic                  dec_valid;
  logic [DATA_WIDTH-1:0] dec_data;
  logic [DATA_WIDTH-1:0] dec_next;
  logic                  mul_valid;
  logic [PW-1:0]         mul_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [PW-1:0]         fifo_dout;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  word_count;

  // Word assembly, last-bit detection, decode mux and effective pop.
  always_comb begin
    word_next = {shift_reg[DATA_WIDTH-2:0], bus.dataIn};
    last_bit  = bus.dataInValid && (bit_cnt == BCW'(DATA_WIDTH - 1));
    dec_next  = (sync_mode == MODE_GRAY)
              ? DATA_WIDTH'(gray2bin(64'(sync_data), 32'(DATA_WIDTH)))
              : sync_data;
    fifo_pop  = bus.dataOutReady && !fifo_empty;
  end

  // Shifter: only valid bits move the register and the bit counter.
  always_ff @(posedge fastClk) begin
    if (reset) begin
      shift_reg <= DATA_WIDTH'(0);
      bit_cnt   <= BCW'(0);
    end else if (bus.dataInValid) begin
      shift_reg <= word_next;
      bit_cnt   <= last_bit ? BCW'(0) : bit_cnt + BCW'(1);
    end else begin
      shift_reg <= shift_reg;
      bit_cnt   <= bit_cnt;
    end
  end

  // Sync stage and word counter: capture the word and its mode on the last-bit edge.
  always_ff @(posedge fastClk) begin
    if (reset) begin
      sync_valid <= 1'b0;
      sync_data  <= DATA_WIDTH'(0);
      sync_mode  <= MODE_PASS;
      word_count <= CNT_WIDTH'(0);
    end else begin
      sync_valid <= last_bit;
      if (last_bit) begin
        sync_data  <= word_next;
        sync_mode  <= mode_e'(bus.control);
        word_count <= word_count + CNT_WIDTH'(1);
      end
    end
  end

  // Decode and multiply stages; coef is sampled when the decoded word moves on.
  always_ff @(posedge fastClk) begin
    if (reset) begin
      dec_valid <= 1'b0;
      dec_data  <= DATA_WIDTH'(0);
      mul_valid <= 1'b0;
      mul_data  <= PW'(0);
    end else begin
      dec_valid <= sync_valid;
      mul_valid <= dec_valid;
      if (sync_valid) begin
        dec_data <= dec_next;
      end
      if (dec_valid) begin
        mul_data <= PW'(dec_data) * PW'(bus.coef);
      end
    end
  end

  // Sticky overflow: a product arrives at a full FIFO that is not popping.
  always_ff @(posedge fastClk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (mul_valid && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else begin
      overflow <= overflow;
    end
  end

  word_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (fastClk),
    .reset (reset),
    .push  (mul_valid),
    .pop   (fifo_pop),
    .din   (mul_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.dataOut      = fifo_dout;
  assign bus.dataOutValid = !fifo_empty;
  assign bus.overflow     = overflow;
  assign bus.wordCount    = word_count;
endmodule
